mcpi_ratio_div: RTL

//  Downstream stage of the Monte Carlo pi sampler.
//  - Consumes one result per completed trial: a valid pulse plus a hit/miss flag.
//  - Counts trials and hits over a fixed window of WINDOW trials.
//  - At each window end it snapshots the hit count and computes pi_est = 4*hits/WINDOW.
//  - Division is a sequential restoring divider, one quotient bit per clock.
//  - Output is a saturated unsigned Q2.FRAC_W value with a one-cycle valid strobe.

---
 rtl/mcpi_ratio_div_if.sv | 21 ++
 rtl/mcpi_ratio_div.sv | 109 ++++++++++
 2 files changed

// File: rtl/mcpi_ratio_div_if.sv
// Trial-result stream into the pi-ratio divider and the estimate/status outputs coming back.
interface mcpi_ratio_div_if #(
  parameter int FRAC_W = 6
);
  logic              trial_valid;
  logic              trial_hit;
  logic [FRAC_W+1:0] est_q;
  logic              est_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output trial_valid, trial_hit,
    input  est_q, est_valid, busy, overrun
  );

  modport slave (
    input  trial_valid, trial_hit,
    output est_q, est_valid, busy, overrun
  );
endinterface

// File: rtl/mcpi_ratio_div.sv
// Windowed hit counter for the Monte Carlo pi sampler; pi_est = 4*hits/WINDOW via a
// bit-serial restoring divider, saturated to unsigned Q2.FRAC_W.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a window end; a window end here starts a divide
// ST_DIV  | one quotient bit per clock, NUM_W iterations
// ST_DONE | saturate/register est_q, pulse est_valid
module mcpi_ratio_div #(
  parameter int CNT_W  = 8,
  parameter int FRAC_W = 6,
  parameter int WINDOW = 200
) (
  input logic             clk,
  input logic             rst,
  mcpi_ratio_div_if.slave bus
);
  localparam int NUM_W  = CNT_W + FRAC_W + 2;
  localparam int ITER_W = $clog2(NUM_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0]  WIN_M1   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W:0]    WIN_R    = (CNT_W + 1)'(WINDOW);
  localparam logic [ITER_W-1:0] ITER_END = ITER_W'(NUM_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  trial_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic [NUM_W-1:0]  num;
  logic [CNT_W:0]    rem;
  logic [NUM_W-1:0]  quot;
  logic [ITER_W-1:0] iter;

  logic              win_end;
  logic [CNT_W-1:0]  hits_fin;
  logic [CNT_W:0]    rem_sh;
  logic              q_bit;
  logic              sat;

  always_comb begin
    win_end  = bus.trial_valid && (trial_cnt == WIN_M1);
    hits_fin = hit_cnt + CNT_W'(bus.trial_hit);
    rem_sh   = {rem[CNT_W-1:0], num[NUM_W-1]};
    // A set top bit means the shifted remainder overflowed its width, so it is >= WINDOW.
    q_bit    = rem[CNT_W] || (rem_sh >= WIN_R);
    sat      = |quot[NUM_W-1:FRAC_W+2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      trial_cnt     <= '0;
      hit_cnt       <= '0;
      num           <= '0;
      rem           <= '0;
      quot          <= '0;
      iter          <= '0;
      bus.est_q     <= '0;
      bus.est_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.trial_valid) begin
        if (win_end) begin
          trial_cnt <= '0;
          hit_cnt   <= '0;
        end else begin
          trial_cnt <= trial_cnt + 1'b1;
          hit_cnt   <= hits_fin;
        end
      end

      bus.est_valid <= 1'b0;
      // busy drops as est_valid falls, unless a new window is accepted on that same edge
      if (bus.est_valid) bus.busy <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win_end) begin
            num      <= {hits_fin, {(FRAC_W + 2){1'b0}}};
            rem      <= '0;
            quot     <= '0;
            iter     <= '0;
            state    <= ST_DIV;
            bus.busy <= 1'b1;
          end
        end
        ST_DIV: begin
          rem  <= q_bit ? (rem_sh - WIN_R) : rem_sh;
          num  <= {num[NUM_W-2:0], 1'b0};
          quot <= {quot[NUM_W-2:0], q_bit};
          iter <= iter + 1'b1;
          if (iter == ITER_END) state <= ST_DONE;
        end
        ST_DONE: begin
          bus.est_q     <= sat ? '1 : quot[FRAC_W+1:0];
          bus.est_valid <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (win_end && (state != ST_IDLE)) bus.overrun <= 1'b1;
    end
  end
endmodule
